// File: rtl/trace_capture_if.sv
// trace_capture_if: commit stream, trace read port and status bundle
// shared between a core-side producer/consumer and the trace capture buffer.
interface trace_capture_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Commit stream from the core
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [31:0]     commit_inst;
  logic            commit_wb_en;
  logic [4:0]      commit_wb_addr;
  logic [XLEN-1:0] commit_wb_data;
  logic            exit_in;

  // Trigger configuration
  logic            trig_en;
  logic [XLEN-1:0] trig_pc;

  // Show-ahead read port
  logic            rd_ready;
  logic            rd_valid;
  logic [XLEN-1:0] rd_pc;
  logic [31:0]     rd_inst;
  logic            rd_wb_en;
  logic [4:0]      rd_wb_addr;
  logic [XLEN-1:0] rd_wb_data;

  // Status
  logic [CW-1:0]    count;
  logic             overflow;
  logic [1:0]       state;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output commit_valid, commit_pc, commit_inst, commit_wb_en, commit_wb_addr,
           commit_wb_data, exit_in, trig_en, trig_pc, rd_ready,
    input  rd_valid, rd_pc, rd_inst, rd_wb_en, rd_wb_addr, rd_wb_data,
           count, overflow, state, retire_cnt
  );

  modport slave (
    input  commit_valid, commit_pc, commit_inst, commit_wb_en, commit_wb_addr,
           commit_wb_data, exit_in, trig_en, trig_pc, rd_ready,
    output rd_valid, rd_pc, rd_inst, rd_wb_en, rd_wb_addr, rd_wb_data,
           count, overflow, state, retire_cnt
  );
endinterface

// File: rtl/trace_capture.sv
// trace_capture: circular buffer of retired-instruction records with a
// pc-match start trigger, freeze on core exit, and wrap or stop-on-full
// behaviour. Entries drain oldest-first through a show-ahead valid/ready port.
module trace_capture #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter bit WRAP  = 1'b1,
  parameter int CNT_W = 32
) (
  input logic            clk,
  input logic            rst_n,
  trace_capture_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_FROZEN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
  } entry_t;

  entry_t           r_mem [DEPTH];
  state_e           r_state;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic [CNT_W-1:0] r_retire_cnt;

  logic   w_trig_fire;
  logic   w_push;
  logic   w_pop;
  logic   w_empty;
  logic   w_full;
  logic   w_lost;
  logic   w_write;
  logic   w_advance_rd;
  entry_t w_entry;
  entry_t w_head;

  // Trigger fires on a matching commit, or on any commit when the trigger is off
  assign w_trig_fire = bus.commit_valid && (!bus.trig_en || (bus.commit_pc == bus.trig_pc));
  // FROZEN never pushes; IDLE pushes only the triggering commit itself
  assign w_push  = bus.commit_valid &&
                   ((r_state == S_CAPTURE) || ((r_state == S_IDLE) && w_trig_fire));
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = !w_empty && bus.rd_ready;
  // A push into a full buffer with no pop loses either the oldest or the new entry
  assign w_lost       = w_push && w_full && !w_pop;
  assign w_write      = w_push && (!w_lost || WRAP);
  // The read pointer also moves when wrap mode overwrites the oldest entry
  assign w_advance_rd = w_pop || (w_lost && WRAP);

  assign w_entry = '{pc:      bus.commit_pc,
                     inst:    bus.commit_inst,
                     wb_en:   bus.commit_wb_en,
                     wb_addr: bus.commit_wb_addr,
                     wb_data: bus.commit_wb_data};

  // Entry storage: written on accepted pushes only
  // NOTE: the storage array has no reset; occupancy lives in r_count, so stale
  // contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= w_entry;
  end

  // Capture FSM: IDLE -> CAPTURE on trigger, IDLE/CAPTURE -> FROZEN on exit
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.exit_in)  r_state <= S_FROZEN;
          else if (w_trig_fire) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (bus.exit_in) r_state <= S_FROZEN;
        end
        default: r_state <= S_FROZEN;
      endcase
    end
  end

  // Pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_write)      r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_advance_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_write && !w_advance_rd)      r_count <= r_count + CW'(1);
      else if (w_advance_rd && !w_write) r_count <= r_count - CW'(1);
      if (w_lost) r_overflow <= 1'b1;
    end
  end

  // Saturating count of retirements seen before the freeze
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (bus.commit_valid && (r_state != S_FROZEN) && (r_retire_cnt != '1)) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  // Head view reads as zero whenever the buffer is empty
  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  assign bus.rd_valid   = !w_empty;
  assign bus.rd_pc      = w_head.pc;
  assign bus.rd_inst    = w_head.inst;
  assign bus.rd_wb_en   = w_head.wb_en;
  assign bus.rd_wb_addr = w_head.wb_addr;
  assign bus.rd_wb_data = w_head.wb_data;
  assign bus.count      = r_count;
  assign bus.overflow   = r_overflow;
  assign bus.state      = r_state;
  assign bus.retire_cnt = r_retire_cnt;
endmodule
